// File: rtl/wash_sequencer.sv
// wash_sequencer: FILL/WASH/RINSE/SPIN phase timer with pause, abort and a one-cycle done pulse.
// Latency: start/abort/pause take effect on the next clk edge; phases step on 1-second prescaler ticks.
// No backpressure: pulse inputs are acted on in the cycle they arrive. `DOOR_LOCK_EN adds a door interlock.
module wash_sequencer #(
    parameter int TICK_DIV = 100000000,
    parameter int FILL_S   = 3,
    parameter int WASH_S   = 6,
    parameter int RINSE_S  = 4,
    parameter int SPIN_S   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       pause_pos,
    input  logic       abort_pos,
    input  logic       ack,
`ifdef DOOR_LOCK_EN
    input  logic       door_open,
    output logic       door_alarm,
`endif
    output logic [2:0] phase,
    output logic [7:0] sec_left,
    output logic [7:0] phase_light,
    output logic       busy,
    output logic       paused,
    output logic       done
);

    localparam logic [2:0] P_IDLE  = 3'd0;
    localparam logic [2:0] P_FILL  = 3'd1;
    localparam logic [2:0] P_WASH  = 3'd2;
    localparam logic [2:0] P_RINSE = 3'd3;
    localparam logic [2:0] P_SPIN  = 3'd4;
    localparam logic [2:0] P_DONE  = 3'd5;

    localparam int             CW       = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  TICK_TOP = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0]  BLNK_TOP = CW'(TICK_DIV / 2 - 1);

    logic [2:0]    phase_q, phase_n;
    logic [7:0]    sec_q, sec_n;
    logic [CW-1:0] presc_q, presc_n;
    logic [CW-1:0] blink_cnt_q;
    logic          blink_q;
    logic          paused_q, paused_n;
    logic [1:0]    mode_q, mode_n;
    logic          done_q, done_n;
    logic          busy_c, tick, start_ok, door_hold;
    logic [7:0]    onehot;

    // Seconds product saturates at 255; a zero product still runs the phase for 1 second.
    function automatic logic [7:0] dur8(input int unsigned secs, input logic [1:0] size);
        logic [31:0] p;
        p = secs * 32'(size);
        if (p == 32'd0)
            return 8'd1;
        else if (p > 32'd255)
            return 8'hFF;
        else
            return p[7:0];
    endfunction

    function automatic logic is_busy(input logic [2:0] ph);
        return (ph >= P_FILL) && (ph <= P_SPIN);
    endfunction

`ifdef DOOR_LOCK_EN
    assign door_hold = door_open;
`else
    assign door_hold = 1'b0;
`endif

    assign busy_c   = is_busy(phase_q);
    assign tick     = busy_c && !paused_q && (presc_q == TICK_TOP);
    assign start_ok = start && (phase_q == P_IDLE || phase_q == P_DONE) && !door_hold;

    always_comb begin
        phase_n  = phase_q;
        sec_n    = sec_q;
        presc_n  = presc_q;
        paused_n = paused_q;
        mode_n   = mode_q;
        done_n   = 1'b0;
        if (abort_pos && busy_c) begin
            phase_n  = P_IDLE;
            sec_n    = 8'd0;
            paused_n = 1'b0;
            presc_n  = '0;
        end else if (start_ok) begin
            mode_n   = mode;
            presc_n  = '0;
            paused_n = 1'b0;
            if (mode == 2'b00) begin
                phase_n = P_SPIN;
                sec_n   = dur8(SPIN_S, 2'd1);
            end else begin
                phase_n = P_FILL;
                sec_n   = dur8(FILL_S, mode);
            end
        end else begin
            if (phase_q == P_DONE && ack)
                phase_n = P_IDLE;
            if (busy_c && !paused_q)
                presc_n = tick ? '0 : presc_q + CW'(1);
            if (tick) begin
                if (sec_q > 8'd1) begin
                    sec_n = sec_q - 8'd1;
                end else begin
                    case (phase_q)
                        P_FILL:  begin phase_n = P_WASH;  sec_n = dur8(WASH_S, mode_q);  end
                        P_WASH:  begin phase_n = P_RINSE; sec_n = dur8(RINSE_S, mode_q); end
                        P_RINSE: begin phase_n = P_SPIN;  sec_n = dur8(SPIN_S, 2'd1);    end
                        P_SPIN:  begin phase_n = P_DONE;  sec_n = 8'd0; done_n = 1'b1;   end
                        default: ;
                    endcase
                end
            end
            // Pause toggles after the tick has been applied; an open door blocks resuming.
            if (pause_pos && is_busy(phase_n) && !(paused_q && door_hold))
                paused_n = !paused_q;
            if (!is_busy(phase_n))
                paused_n = 1'b0;
        end
        if (is_busy(phase_n) && door_hold)
            paused_n = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q  <= P_IDLE;
            sec_q    <= 8'd0;
            presc_q  <= '0;
            paused_q <= 1'b0;
            mode_q   <= 2'b00;
            done_q   <= 1'b0;
        end else begin
            phase_q  <= phase_n;
            sec_q    <= sec_n;
            presc_q  <= presc_n;
            paused_q <= paused_n;
            mode_q   <= mode_n;
            done_q   <= done_n;
        end
    end

    // Free-running half-second toggle drives the paused blink.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (blink_cnt_q == BLNK_TOP) begin
            blink_cnt_q <= '0;
            blink_q     <= !blink_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + CW'(1);
        end
    end

`ifdef DOOR_LOCK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            door_alarm <= 1'b0;
        else
            door_alarm <= is_busy(phase_n) && door_open;
    end
`endif

    always_comb begin
        case (phase_q)
            P_FILL:  onehot = 8'h01;
            P_WASH:  onehot = 8'h02;
            P_RINSE: onehot = 8'h04;
            P_SPIN:  onehot = 8'h08;
            P_DONE:  onehot = 8'h80;
            default: onehot = 8'h00;
        endcase
        phase_light = paused_q ? (onehot & {8{blink_q}}) : onehot;
    end

    assign phase    = phase_q;
    assign sec_left = sec_q;
    assign busy     = busy_c;
    assign paused   = paused_q;
    assign done     = done_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer with a per-cycle elapsed-time model and literal spot checks.
module tb_wash_sequencer;
    localparam int TD = 4;

    logic       clk, rst, start, pause_pos, abort_pos, ack, door_open;
    logic [1:0] mode;
    logic [2:0] phase;
    logic [7:0] sec_left, phase_light;
    logic       busy, paused, done, door_alarm;
    logic       door_eff;

    int n_cmp = 0;
    int n_bad = 0;

    wash_sequencer #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .pause_pos(pause_pos), .abort_pos(abort_pos), .ack(ack),
`ifdef DOOR_LOCK_EN
        .door_open(door_open), .door_alarm(door_alarm),
`endif
        .phase(phase), .sec_left(sec_left), .phase_light(phase_light),
        .busy(busy), .paused(paused), .done(done)
    );

`ifdef DOOR_LOCK_EN
    assign door_eff = door_open;
`else
    assign door_eff   = 1'b0;
    assign door_alarm = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase plus count of running cycles spent in it; sec_left derives from that.
    int m_phase, m_mode, m_run, m_cyc;
    bit m_paused, m_done, m_alarm, m_wb;

    function automatic int dur_of(input int ph, input int md);
        int p;
        case (ph)
            1: p = 3 * md;
            2: p = 6 * md;
            3: p = 4 * md;
            default: p = 5;
        endcase
        if (p > 255) p = 255;
        if (p == 0) p = 1;
        return p;
    endfunction

    function automatic bit m_busy(input int ph);
        return ph >= 1 && ph <= 4;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0; m_mode = 0; m_run = 0; m_cyc = 0;
            m_paused = 0; m_done = 0; m_alarm = 0;
        end else begin
            m_wb = m_busy(m_phase);
            m_cyc++;
            m_done = 0;
            if (abort_pos && m_wb) begin
                m_phase = 0; m_paused = 0; m_run = 0;
            end else if (start && (m_phase == 0 || m_phase == 5) && !door_eff) begin
                m_mode = int'(mode); m_run = 0; m_paused = 0;
                m_phase = (mode == 2'b00) ? 4 : 1;
            end else begin
                if (m_phase == 5 && ack) m_phase = 0;
                if (m_wb && !m_paused) begin
                    m_run++;
                    if (m_run == dur_of(m_phase, m_mode) * TD) begin
                        m_run = 0;
                        m_phase++;
                        if (m_phase == 5) m_done = 1;
                    end
                end
                if (pause_pos && m_busy(m_phase) && !(m_paused && door_eff)) m_paused = !m_paused;
                if (!m_busy(m_phase)) m_paused = 0;
            end
            if (m_busy(m_phase) && door_eff) m_paused = 1;
            m_alarm = m_busy(m_phase) && door_eff;
        end
    end

    function automatic int exp_sec();
        return m_busy(m_phase) ? dur_of(m_phase, m_mode) - m_run / TD : 0;
    endfunction

    function automatic int exp_light();
        logic [7:0] oh;
        bit blink;
        case (m_phase)
            1: oh = 8'h01; 2: oh = 8'h02; 3: oh = 8'h04; 4: oh = 8'h08; 5: oh = 8'h80;
            default: oh = 8'h00;
        endcase
        blink = ((m_cyc / (TD / 2)) % 2) == 1;
        return int'(m_paused ? (oh & {8{blink}}) : oh);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("phase", int'(phase), m_phase);
            chk("sec_left", int'(sec_left), exp_sec());
            chk("phase_light", int'(phase_light), exp_light());
            chk("busy", int'(busy), int'(m_busy(m_phase)));
            chk("paused", int'(paused), int'(m_paused));
            chk("done", int'(done), int'(m_done));
`ifdef DOOR_LOCK_EN
            chk("door_alarm", int'(door_alarm), int'(m_alarm));
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] m);
        mode = m; start = 1'b1; step(1); start = 1'b0;
    endtask

    task automatic do_pause();
        pause_pos = 1'b1; step(1); pause_pos = 1'b0;
    endtask

    task automatic do_abort();
        abort_pos = 1'b1; step(1); abort_pos = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 0; pause_pos = 0; abort_pos = 0; ack = 0; door_open = 0; mode = 2'b00;
        #2;
        chk("rst phase", int'(phase), 0);
        chk("rst sec_left", int'(sec_left), 0);
        chk("rst light", int'(phase_light), 0);
        chk("rst done", int'(done), 0);
        @(negedge clk) rst = 1'b1;
        step(1);

        do_pause();
        chk("idle pause ignored", int'(paused), 0);

        // Small load: 3 + 6 + 4 + 5 seconds at 4 cycles each.
        do_start(2'b01);
        chk("m1 fill phase", int'(phase), 1);
        chk("m1 fill sec", int'(sec_left), 3);
        step(11);
        chk("m1 fill last sec", int'(sec_left), 1);
        step(1);
        chk("m1 wash phase", int'(phase), 2);
        chk("m1 wash sec", int'(sec_left), 6);
        step(24);
        chk("m1 rinse sec", int'(sec_left), 4);
        step(16);
        chk("m1 spin sec", int'(sec_left), 5);
        step(20);
        chk("m1 done pulse", int'(done), 1);
        chk("m1 done phase", int'(phase), 5);

        // DONE with start and ack together restarts.
        mode = 2'b01; start = 1'b1; ack = 1'b1; step(1); start = 1'b0; ack = 1'b0;
        chk("restart phase", int'(phase), 1);
        chk("restart sec", int'(sec_left), 3);
        step(40);
        do_start(2'b11);
        chk("start in rinse", int'(phase), 3);
        step(30);
        abort_pos = 1'b1; step(1); abort_pos = 1'b0;
        chk("abort at tick phase", int'(phase), 0);
        chk("abort at tick done", int'(done), 0);
        step(1);
        chk("abort no done", int'(done), 0);

        do_start(2'b00);
        chk("spin only phase", int'(phase), 4);
        chk("spin only sec", int'(sec_left), 5);
        step(19);
        chk("spin only early", int'(done), 0);
        step(1);
        chk("spin only done", int'(done), 1);
        step(1);
        chk("done one cycle", int'(done), 0);
        ack = 1'b1; step(1); ack = 1'b0;
        chk("ack idle", int'(phase), 0);

        // Large load, pause mid-wash at sec 4 / prescaler 2.
        do_start(2'b11);
        chk("m3 fill sec", int'(sec_left), 9);
        step(36);
        chk("m3 wash sec", int'(sec_left), 18);
        step(58);
        do_pause();
        chk("pause set", int'(paused), 1);
        chk("pause sec", int'(sec_left), 4);
        step(50);
        chk("frozen sec", int'(sec_left), 4);
        chk("frozen phase", int'(phase), 2);
        do_pause();
        chk("resume sec", int'(sec_left), 4);
        step(1);
        chk("resume decrement", int'(sec_left), 3);
        do_abort();

        // Pause arriving with a tick: decrement lands, then pause sets.
        do_start(2'b01);
        step(3);
        do_pause();
        chk("tick+pause sec", int'(sec_left), 2);
        chk("tick+pause paused", int'(paused), 1);
        step(5);
        do_pause();
        step(3);

        // Asynchronous reset between clock edges.
        #2 rst = 1'b0;
        #1;
        chk("async phase", int'(phase), 0);
        chk("async sec", int'(sec_left), 0);
        chk("async light", int'(phase_light), 0);
        chk("async busy", int'(busy), 0);
        chk("async paused", int'(paused), 0);
        @(negedge clk) rst = 1'b1;
        step(1);

`ifdef DOOR_LOCK_EN
        do_start(2'b01);
        step(14);
        door_open = 1'b1; step(1);
        chk("door paused", int'(paused), 1);
        chk("door alarm", int'(door_alarm), 1);
        do_pause();
        chk("door hold", int'(paused), 1);
        door_open = 1'b0; step(1);
        chk("door closed alarm", int'(door_alarm), 0);
        chk("door closed paused", int'(paused), 1);
        do_pause();
        chk("door resume", int'(paused), 0);
        step(8);
        do_abort();
        door_open = 1'b1;
        do_start(2'b01);
        chk("door blocks start", int'(phase), 0);
        door_open = 1'b0;
        step(2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
